cacheline_adaptor: RTL and testbench
====================================

CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 Parameter BURST_LEN, default 4, is the number of beats per line transfer.
REQ-002 Parameter CACHE_LINE_WIDTH, default 256, is the line width in bits.
REQ-003 Derived constant BURST_WIDTH SHALL equal CACHE_LINE_WIDTH/BURST_LEN (default 64); OFFSET_BITS SHALL equal log2(CACHE_LINE_WIDTH/8) (default 5).
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 line_i  in  CACHE_LINE_WIDTH  write line from the cache side.
REQ-007 line_o  out  CACHE_LINE_WIDTH  read line to the cache side; valid while resp_o=1.
REQ-008 address_i  in  32  byte address from the cache side.
REQ-009 read_i / write_i  in  1 each  cache-side line request; held until resp_o or err_o.
REQ-010 resp_o  out  1  one-cycle completion pulse.
REQ-011 err_o  out  1  one-cycle failure pulse.
REQ-012 burst_i  in  BURST_WIDTH  read beat from memory.
REQ-013 burst_o  out  BURST_WIDTH  write beat to memory.
REQ-014 address_o  out  32  line-aligned address to memory.
REQ-015 read_o / write_o  out  1 each  memory request; held steady for the whole burst.
REQ-016 resp_i  in  1  memory beat strobe.
REQ-017 error_i  in  1  memory protocol-error flag.

Function
REQ-018 FSM states SHALL be IDLE, READ, WRITE, DONE.
REQ-019 In IDLE, read_i=1 with write_i=0 SHALL latch address_i and go to READ; write_i=1 with read_i=0 SHALL latch address_i and line_i and go to WRITE.
REQ-020 In IDLE, read_i=1 with write_i=1 SHALL start no transfer, stay in IDLE, and pulse err_o for one cycle.
REQ-021 address_o SHALL equal the latched address with bits [OFFSET_BITS-1:0] forced to 0, constant from acceptance to completion.
REQ-022 read_o SHALL be 1 exactly while in READ; write_o SHALL be 1 exactly while in WRITE; both SHALL never be 1 together.
REQ-023 A beat counter of width log2(BURST_LEN) SHALL be cleared on acceptance and incremented on each clock edge at which resp_i=1 in READ or WRITE.
REQ-024 READ: on each edge with resp_i=1, burst_i SHALL be stored into line slot [BURST_WIDTH*cnt +: BURST_WIDTH].
REQ-025 WRITE: burst_o SHALL combinationally present latched line slot [BURST_WIDTH*cnt +: BURST_WIDTH] at all times, so beat 0 is driven before the first resp_i.
REQ-026 The edge that consumes the final beat (cnt=BURST_LEN-1, resp_i=1) SHALL move the FSM to DONE, deasserting read_o or write_o in the next cycle.
REQ-027 DONE SHALL last exactly one cycle with resp_o=1 and line_o holding the assembled line (read) or the unchanged latched line (write), then return to IDLE.
REQ-028 line_o SHALL keep its value until the next read completes.
REQ-029 error_i=1 sampled in READ or WRITE SHALL abort to IDLE, pulse err_o for one cycle, and suppress resp_o.
REQ-030 resp_i and error_i SHALL be ignored in IDLE and DONE.
REQ-031 Requests SHALL be sampled only in IDLE; a request held into the IDLE cycle after DONE starts a new transfer.
REQ-032 Latency: read_o or write_o SHALL rise one cycle after acceptance; resp_o SHALL rise one cycle after the final beat edge.

Reset
REQ-033 rst=0 SHALL immediately force state IDLE, cnt 0, read_o 0, write_o 0, resp_o 0, err_o 0, address_o 0, line_o 0, latched line 0, and therefore burst_o 0.
REQ-034 Reset asserted mid-burst SHALL abandon the transfer without a resp_o or err_o pulse.

Structure
REQ-035 Package cacheline_adaptor_pkg SHALL hold the state enum and the BURST_LEN, CACHE_LINE_WIDTH, BURST_WIDTH and OFFSET_BITS defaults.
REQ-036 The block SHALL be a single module with no sub-modules.

Verification
REQ-037 Read of address_i=0x0000_1234 with memory returning beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> address_o=0x0000_1220; read_o held; resp_o one cycle; line_o={0x44..,0x33..,0x22..,0x11..}.
REQ-038 Write of line_i with slots k=0xA0+k and 3-cycle memory delay -> burst_o=slot k on each resp_i edge; write_o drops after beat 3; resp_o one cycle.
REQ-039 read_i=write_i=1 in IDLE -> err_o for one cycle; read_o=write_o=0.
REQ-040 error_i=1 after beat 1 of a read -> err_o pulse; read_o low the next cycle; no resp_o.
REQ-041 rst=0 during write beat 2 -> all outputs 0 asynchronously; no resp_o after release.
REQ-042 Back-to-back read then write, with read_i dropped and write_i raised in the resp_o cycle -> the second transfer starts exactly one cycle after DONE.

Source files
------------

// File: rtl/cacheline_adaptor_pkg.sv
// Shared definitions for the cache-line <-> burst adaptor.
// Holds the default geometry (beats per line, line width, derived beat
// width and byte-offset width) and the controller state encoding.
package cacheline_adaptor_pkg;

    localparam int DEF_BURST_LEN        = 4;
    localparam int DEF_CACHE_LINE_WIDTH = 256;
    localparam int DEF_BURST_WIDTH      = DEF_CACHE_LINE_WIDTH / DEF_BURST_LEN;
    localparam int DEF_OFFSET_BITS      = $clog2(DEF_CACHE_LINE_WIDTH / 8);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Beat counter width; a single-beat line still needs a 1-bit counter.
    function automatic int cnt_width(input int burst_len);
        return (burst_len > 1) ? $clog2(burst_len) : 1;
    endfunction

endpackage

// File: rtl/cacheline_adaptor.sv
// Cache-line adaptor: converts one cache-side line read/write request into
// a BURST_LEN-beat burst on the memory side.
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous reset, active low
//   line_i     write line from the cache
//   line_o     read line to the cache (valid while resp_o=1)
//   address_i  byte address from the cache
//   read_i     cache line read request (held until resp_o or err_o)
//   write_i    cache line write request (held until resp_o or err_o)
//   resp_o     one-cycle completion pulse
//   err_o      one-cycle failure pulse (request conflict or memory error)
//   burst_i    read beat from memory
//   burst_o    write beat to memory
//   address_o  line-aligned address to memory
//   read_o     memory read request, held for the whole burst
//   write_o    memory write request, held for the whole burst
//   resp_i     memory beat strobe
//   error_i    memory protocol-error flag
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a cache request; requests only sampled here
// READ  | read_o high, one beat stored per resp_i
// WRITE | write_o high, burst_o shows the current slot of the latched line
// DONE  | one cycle, resp_o high, line_o presents the finished line
module cacheline_adaptor
    import cacheline_adaptor_pkg::*;
#(
    parameter int BURST_LEN        = DEF_BURST_LEN,
    parameter int CACHE_LINE_WIDTH = DEF_CACHE_LINE_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst,

    input  logic [CACHE_LINE_WIDTH-1:0]     line_i,
    output logic [CACHE_LINE_WIDTH-1:0]     line_o,
    input  logic [31:0]                     address_i,
    input  logic                            read_i,
    input  logic                            write_i,
    output logic                            resp_o,
    output logic                            err_o,

    input  logic [CACHE_LINE_WIDTH/BURST_LEN-1:0] burst_i,
    output logic [CACHE_LINE_WIDTH/BURST_LEN-1:0] burst_o,
    output logic [31:0]                     address_o,
    output logic                            read_o,
    output logic                            write_o,
    input  logic                            resp_i,
    input  logic                            error_i
);

    localparam int BURST_WIDTH = CACHE_LINE_WIDTH / BURST_LEN;
    localparam int OFFSET_BITS = $clog2(CACHE_LINE_WIDTH / 8);
    localparam int CNT_W       = cnt_width(BURST_LEN);

    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(BURST_LEN - 1);
    localparam logic [31:0]      ADDR_MASK = ~((32'd1 << OFFSET_BITS) - 32'd1);

    state_t                         state_q;
    state_t                         state_d;
    logic [CNT_W-1:0]               cnt_q;
    logic [31:0]                    addr_q;
    // Write data on a write; assembly buffer on a read.
    logic [CACHE_LINE_WIDTH-1:0]    buf_q;
    logic [CACHE_LINE_WIDTH-1:0]    rd_line_q;
    logic [CACHE_LINE_WIDTH-1:0]    rd_line_d;
    logic                           dir_write_q;
    logic                           err_q;

    logic                           accept_rd;
    logic                           accept_wr;
    logic                           req_conflict;
    logic                           beat;
    logic                           last_beat;
    logic                           abort;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        accept_rd    = 1'b0;
        accept_wr    = 1'b0;
        req_conflict = 1'b0;
        beat         = 1'b0;
        last_beat    = 1'b0;
        abort        = 1'b0;
        read_o       = 1'b0;
        write_o      = 1'b0;
        resp_o       = 1'b0;

        case (state_q)
            IDLE: begin
                if (read_i && write_i) begin
                    req_conflict = 1'b1;
                end else if (read_i) begin
                    accept_rd = 1'b1;
                    state_d   = READ;
                end else if (write_i) begin
                    accept_wr = 1'b1;
                    state_d   = WRITE;
                end
            end

            READ, WRITE: begin
                read_o  = (state_q == READ);
                write_o = (state_q == WRITE);
                // A memory error wins over a beat strobe in the same cycle.
                if (error_i) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else if (resp_i) begin
                    beat = 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        last_beat = 1'b1;
                        state_d   = DONE;
                    end
                end
            end

            DONE: begin
                resp_o  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Finished read line: everything assembled so far plus the final beat,
    // so line_o can be updated on the same edge that consumes that beat.
    always_comb begin
        rd_line_d = buf_q;
        rd_line_d[int'(cnt_q)*BURST_WIDTH +: BURST_WIDTH] = burst_i;
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            addr_q      <= '0;
            buf_q       <= '0;
            rd_line_q   <= '0;
            dir_write_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= req_conflict | abort;

            if (accept_rd || accept_wr) begin
                addr_q      <= address_i & ADDR_MASK;
                cnt_q       <= '0;
                dir_write_q <= accept_wr;
            end

            if (accept_wr) begin
                buf_q <= line_i;
            end

            if (beat) begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (state_q == READ) begin
                    buf_q[int'(cnt_q)*BURST_WIDTH +: BURST_WIDTH] <= burst_i;
                end
            end

            if (last_beat && (state_q == READ)) begin
                rd_line_q <= rd_line_d;
            end
        end
    end

    assign address_o = addr_q;
    assign err_o     = err_q;
    assign burst_o   = buf_q[int'(cnt_q)*BURST_WIDTH +: BURST_WIDTH];

    // A completing write shows its own line during the DONE cycle only;
    // otherwise the last completed read line is held.
    assign line_o = ((state_q == DONE) && dir_write_q) ? buf_q : rd_line_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor (default 4 x 64-bit geometry).
// The bench acts as both cache and memory; expected values come from the
// transaction parameters (line data, aligned address, beat timing).
module tb_cacheline_adaptor;

    logic          clk;
    logic          rst;
    logic [255:0]  line_i;
    logic [255:0]  line_o;
    logic [31:0]   address_i;
    logic          read_i;
    logic          write_i;
    logic          resp_o;
    logic          err_o;
    logic [63:0]   burst_i;
    logic [63:0]   burst_o;
    logic [31:0]   address_o;
    logic          read_o;
    logic          write_o;
    logic          resp_i;
    logic          error_i;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [255:0]  last_rd = '0;

    cacheline_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .err_o     (err_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i),
        .error_i   (error_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          kind;      // 0 read, 1 write, 2 conflicting request
        logic [31:0] addr;
        int          pat;       // 0: 11..44 beats, 1: A0+k slots, 2: random
        int          dly;       // idle cycles before each beat, -1 random
        int          err_beat;  // beat index replaced by error_i, -1 none
        logic [31:0] exp_addr;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] mk_line(input int pat);
        logic [255:0] l;
        l = '0;
        for (int k = 0; k < 4; k++) begin
            case (pat)
                0:       l[k*64 +: 64] = {16{4'(k + 1)}};
                1:       l[k*64 +: 64] = {8{8'(8'hA0 + k)}};
                default: l[k*64 +: 64] = {$urandom, $urandom};
            endcase
        end
        return l;
    endfunction

    function automatic logic [255:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
    endfunction

    // One complete cache transaction. from_done: called during a DONE cycle
    // with the new request raised there. chain_out: return in the DONE
    // cycle with the request still held so the caller can chain.
    task automatic do_xfer(input int kind, input logic [31:0] addr, input logic [255:0] data,
                           input logic [31:0] exp_addr, input int dly, input int err_beat,
                           input bit from_done, input bit chain_out);
        int d;
        logic [1:0] busy;
        busy      = (kind == 0) ? 2'b10 : 2'b01;
        read_i    = (kind == 0);
        write_i   = (kind == 1);
        address_i = addr;
        line_i    = (kind == 1) ? data : rnd_line();
        if (from_done) begin
            tick();
            chk("gap_idle", {read_o, write_o}, 2'b00);
            chk("gap_resp", resp_o, 1'b0);
        end
        tick();
        line_i    = rnd_line();
        address_i = $urandom;
        chk("req_rise", {read_o, write_o}, busy);
        chk("addr_o", address_o, exp_addr);
        for (int k = 0; k < 4; k++) begin
            d = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
            for (int i = 0; i < d; i++) begin
                burst_i = {$urandom, $urandom};
                if (kind == 1) chk("burst_o_wait", burst_o, data[k*64 +: 64]);
                tick();
                chk("req_held", {read_o, write_o}, busy);
                chk("addr_held", address_o, exp_addr);
                chk("no_resp_mid", resp_o, 1'b0);
            end
            if (k == err_beat) begin
                error_i = 1'b1;
                resp_i  = 1'($urandom_range(0, 1));
                tick();
                error_i = 1'b0;
                resp_i  = 1'b0;
                chk("abort_err", err_o, 1'b1);
                chk("abort_idle", {read_o, write_o}, 2'b00);
                chk("abort_noresp", resp_o, 1'b0);
                read_i  = 1'b0;
                write_i = 1'b0;
                tick();
                chk("abort_err_once", err_o, 1'b0);
                chk("abort_noresp2", resp_o, 1'b0);
                chk("abort_line", line_o, last_rd);
                return;
            end
            resp_i  = 1'b1;
            burst_i = data[k*64 +: 64];
            if (kind == 1) chk("burst_o", burst_o, data[k*64 +: 64]);
            tick();
            resp_i  = 1'b0;
            burst_i = {$urandom, $urandom};
            if (k < 3) begin
                chk("req_held_beat", {read_o, write_o}, busy);
                chk("no_resp_beat", resp_o, 1'b0);
            end
        end
        chk("done_resp", resp_o, 1'b1);
        chk("done_idle", {read_o, write_o}, 2'b00);
        chk("done_noerr", err_o, 1'b0);
        chk("done_line", line_o, data);
        if (kind == 0) last_rd = data;
        if (chain_out) return;
        // Strobes in DONE and IDLE must be ignored.
        read_i  = 1'b0;
        write_i = 1'b0;
        resp_i  = 1'b1;
        error_i = 1'b1;
        tick();
        chk("resp_once", resp_o, 1'b0);
        chk("done_ign_err", err_o, 1'b0);
        chk("idle_line", line_o, last_rd);
        tick();
        resp_i  = 1'b0;
        error_i = 1'b0;
        chk("idle_ign_err", err_o, 1'b0);
        chk("idle_ign_busy", {read_o, write_o}, 2'b00);
        chk("idle_ign_resp", resp_o, 1'b0);
    endtask

    task automatic do_conflict();
        read_i    = 1'b1;
        write_i   = 1'b1;
        address_i = $urandom;
        tick();
        chk("conf_err", err_o, 1'b1);
        chk("conf_idle", {read_o, write_o}, 2'b00);
        chk("conf_noresp", resp_o, 1'b0);
        read_i  = 1'b0;
        write_i = 1'b0;
        tick();
        chk("conf_err_once", err_o, 1'b0);
        chk("conf_still_idle", {read_o, write_o}, 2'b00);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{0, 32'h0000_1234, 0,  0, -1, 32'h0000_1220};
        vecs[1] = '{1, 32'h8000_0040, 1,  3, -1, 32'h8000_0040};
        vecs[2] = '{0, 32'hFFFF_FFFF, 2,  1, -1, 32'hFFFF_FFE0};
        vecs[3] = '{0, 32'h0000_003F, 2,  0,  1, 32'h0000_0020};
        vecs[4] = '{1, 32'h0000_001F, 2,  2,  0, 32'h0000_0000};
        vecs[5] = '{2, 32'h0000_0000, 2,  0, -1, 32'h0000_0000};
        vecs[6] = '{1, 32'hDEAD_BEEF, 1,  0,  3, 32'hDEAD_BEE0};
        vecs[7] = '{0, 32'h0000_0020, 0,  2, -1, 32'h0000_0020};

        rst       = 1'b0;
        line_i    = '0;
        address_i = '0;
        read_i    = 1'b0;
        write_i   = 1'b0;
        burst_i   = '0;
        resp_i    = 1'b0;
        error_i   = 1'b0;
        tick();
        tick();
        chk("rst_busy", {read_o, write_o}, 2'b00);
        chk("rst_resp_err", {resp_o, err_o}, 2'b00);
        chk("rst_addr", address_o, 32'h0);
        chk("rst_line", line_o, 256'h0);
        chk("rst_burst", burst_o, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Directed table
        for (int v = 0; v < 8; v++) begin
            if (vecs[v].kind == 2) begin
                do_conflict();
            end else begin
                do_xfer(vecs[v].kind, vecs[v].addr, mk_line(vecs[v].pat), vecs[v].exp_addr,
                        vecs[v].dly, vecs[v].err_beat, 1'b0, 1'b0);
            end
        end

        // Back-to-back: read, then write raised in the resp_o cycle
        do_xfer(0, 32'h0000_4444, mk_line(2), 32'h0000_4440, 0, -1, 1'b0, 1'b1);
        do_xfer(1, 32'h0000_5555, mk_line(1), 32'h0000_5540, 1, -1, 1'b1, 1'b0);

        // Reset during write beat 2
        write_i   = 1'b1;
        address_i = 32'h0000_7777;
        line_i    = mk_line(2);
        tick();
        resp_i = 1'b1;
        tick();
        tick();
        chk("pre_rst_busy", write_o, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_busy", {read_o, write_o}, 2'b00);
        chk("arst_resp_err", {resp_o, err_o}, 2'b00);
        chk("arst_addr", address_o, 32'h0);
        chk("arst_line", line_o, 256'h0);
        chk("arst_burst", burst_o, 64'h0);
        write_i = 1'b0;
        resp_i  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        last_rd = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_quiet", {resp_o, err_o, read_o, write_o}, 4'b0000);
        end

        // Randomized transactions
        for (int t = 0; t < 40; t++) begin
            int kind;
            int eb;
            logic [31:0] a;
            kind = ($urandom_range(0, 9) == 0) ? 2 : int'($urandom_range(0, 1));
            eb   = ($urandom_range(0, 6) == 0) ? int'($urandom_range(0, 3)) : -1;
            a    = $urandom;
            if (kind == 2) begin
                do_conflict();
            end else begin
                do_xfer(kind, a, rnd_line(), a & 32'hFFFF_FFE0, -1, eb, 1'b0, 1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
